// File: rtl/aes_spi_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module  : aes_spi_sequencer_if
// Brief   : SPI-frame and AES-core signal bundle for the AES/SPI sequencer.
// Revision: 1.0 - initial release
// ============================================================================
interface aes_spi_sequencer_if #(
    parameter int Nk = 4
);
    logic             spi_ready;
    logic             spi_cs;
    logic [127:0]     spi_message;
    logic [Nk*32-1:0] spi_key;
    logic [127:0]     spi_processed;
    logic [127:0]     core_data;
    logic [Nk*32-1:0] core_key;
    logic             core_start;
    logic             core_done;
    logic [127:0]     core_result;
    logic             busy;
    logic             result_valid;
    logic             overrun;
    logic             timeout_err;

    // Sequencer side
    modport master (
        input  spi_ready, spi_cs, spi_message, spi_key, core_done, core_result,
        output spi_processed, core_data, core_key, core_start,
               busy, result_valid, overrun, timeout_err
    );

    // SPI block / AES core side
    modport slave (
        output spi_ready, spi_cs, spi_message, spi_key, core_done, core_result,
        input  spi_processed, core_data, core_key, core_start,
               busy, result_valid, overrun, timeout_err
    );
endinterface
`default_nettype wire

// File: rtl/aes_spi_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : aes_spi_sequencer
// Brief   : Latches SPI frames into the AES core, starts it, waits under a
//           watchdog and writes the ciphertext back when SPI is idle.
// Revision: 1.0 - initial release
// ============================================================================
module aes_spi_sequencer #(
    parameter int Nk      = 4,
    parameter int TIMEOUT = 64
) (
    input  wire                  clk,
    input  wire                  rst,
    aes_spi_sequencer_if.master  bus
);
    localparam int                c_WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [c_WD_W-1:0] c_WD_LAST = c_WD_W'(TIMEOUT - 1);
    localparam logic [c_WD_W-1:0] c_WD_ONE  = c_WD_W'(1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CAPTURE = 3'd1,
        S_START   = 3'd2,
        S_BUSY    = 3'd3,
        S_WAIT_CS = 3'd4,
        S_WRITE   = 3'd5
    } state_t;

    state_t             r_state;
    logic               r_ready_q;
    logic [c_WD_W-1:0]  r_wd;
    logic [127:0]       r_res;
    logic [127:0]       r_spi_processed;
    logic [127:0]       r_core_data;
    logic [Nk*32-1:0]   r_core_key;
    logic               r_result_valid;
    logic               r_overrun;
    logic               r_timeout_err;
    logic               w_frame_evt;

    assign w_frame_evt = bus.spi_ready & ~r_ready_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_ready_q       <= 1'b0;
            r_wd            <= '0;
            r_res           <= '0;
            r_spi_processed <= '0;
            r_core_data     <= '0;
            r_core_key      <= '0;
            r_result_valid  <= 1'b0;
            r_overrun       <= 1'b0;
            r_timeout_err   <= 1'b0;
        end else begin
            r_ready_q <= bus.spi_ready;
            // A frame arriving mid-operation is dropped; only the flag records it
            if (w_frame_evt && r_state != S_IDLE)
                r_overrun <= 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (w_frame_evt) begin
                        r_core_data    <= bus.spi_message;
                        r_core_key     <= bus.spi_key;
                        r_result_valid <= 1'b0;
                        r_overrun      <= 1'b0;
                        r_timeout_err  <= 1'b0;
                        r_state        <= S_CAPTURE;
                    end
                end
                S_CAPTURE: r_state <= S_START;
                S_START: begin
                    r_wd    <= '0;
                    r_state <= S_BUSY;
                end
                S_BUSY: begin
                    r_wd <= r_wd + c_WD_ONE;
                    if (bus.core_done) begin
                        r_res   <= bus.core_result;
                        r_state <= bus.spi_cs ? S_WAIT_CS : S_WRITE;
                    end else if (r_wd == c_WD_LAST) begin
                        r_timeout_err <= 1'b1;
                        r_state       <= S_IDLE;
                    end
                end
                S_WAIT_CS: begin
                    if (!bus.spi_cs)
                        r_state <= S_WRITE;
                end
                S_WRITE: begin
                    r_spi_processed <= r_res;
                    r_result_valid  <= 1'b1;
                    r_state         <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.core_start    = (r_state == S_START);
    assign bus.busy          = (r_state != S_IDLE);
    assign bus.spi_processed = r_spi_processed;
    assign bus.core_data     = r_core_data;
    assign bus.core_key      = r_core_key;
    assign bus.result_valid  = r_result_valid;
    assign bus.overrun       = r_overrun;
    assign bus.timeout_err   = r_timeout_err;
endmodule
`default_nettype wire

// File: tb/tb_aes_spi_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_aes_spi_sequencer
// Brief   : Directed self-checking bench for aes_spi_sequencer.
// Revision: 1.0 - initial release
// ============================================================================
module tb_aes_spi_sequencer;
    localparam logic [127:0] c_M1 = 128'h00112233_44556677_8899aabb_ccddeeff;
    localparam logic [127:0] c_M2 = 128'hdeadbeef_01234567_89abcdef_cafef00d;
    localparam logic [127:0] c_M3 = 128'h11111111_22222222_33333333_44444444;
    localparam logic [127:0] c_M4 = 128'h55555555_66666666_77777777_88888888;
    localparam logic [127:0] c_K1 = 128'h00010203_04050607_08090a0b_0c0d0e0f;
    localparam logic [255:0] c_K2 = 256'h00010203_04050607_08090a0b_0c0d0e0f_10111213_14151617_18191a1b_1c1d1e1f;
    localparam logic [127:0] c_C1 = 128'h69c4e0d8_6a7b0430_d8cdb780_70b4c55a;
    localparam logic [127:0] c_C2 = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
    localparam logic [127:0] c_C3 = 128'ha5a5a5a5_5a5a5a5a_f0f0f0f0_0f0f0f0f;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    aes_spi_sequencer_if #(.Nk(4)) bus_a ();
    aes_spi_sequencer_if #(.Nk(8)) bus_b ();

    aes_spi_sequencer #(.Nk(4), .TIMEOUT(64)) u_dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    aes_spi_sequencer #(.Nk(8), .TIMEOUT(8))  u_dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        bus_a.spi_ready = 0; bus_a.spi_cs = 0; bus_a.spi_message = '0; bus_a.spi_key = '0;
        bus_a.core_done = 0; bus_a.core_result = '0;
        bus_b.spi_ready = 0; bus_b.spi_cs = 0; bus_b.spi_message = '0; bus_b.spi_key = '0;
        bus_b.core_done = 0; bus_b.core_result = '0;

        tick(2);
        check("rst_busy",    256'(bus_a.busy), 256'(0));
        check("rst_proc",    256'(bus_a.spi_processed), 256'(0));
        check("rst_rv",      256'(bus_a.result_valid), 256'(0));
        check("rst_key_b",   256'(bus_b.core_key), 256'(0));
        rst = 0;
        tick();

        // Basic: frame at T, start at T+2, done 10 cycles after start
        bus_a.spi_message = c_M1; bus_a.spi_key = c_K1;
        tick();
        bus_a.spi_ready = 1;
        tick();
        check("basic_data",   256'(bus_a.core_data), 256'(c_M1));
        check("basic_key",    256'(bus_a.core_key), 256'(c_K1));
        check("basic_nostart",256'(bus_a.core_start), 256'(0));
        check("basic_busy",   256'(bus_a.busy), 256'(1));
        tick();
        check("basic_start",  256'(bus_a.core_start), 256'(1));
        tick();
        check("basic_start1", 256'(bus_a.core_start), 256'(0));
        tick(9);
        bus_a.core_done = 1; bus_a.core_result = c_C1;
        tick();
        bus_a.core_done = 0; bus_a.core_result = '0;
        check("basic_rv_d1",  256'(bus_a.result_valid), 256'(0));
        tick();
        check("basic_proc",   256'(bus_a.spi_processed), 256'(c_C1));
        check("basic_rv",     256'(bus_a.result_valid), 256'(1));
        check("basic_idle",   256'(bus_a.busy), 256'(0));
        check("basic_held",   256'(bus_a.overrun), 256'(0));
        bus_a.spi_ready = 0;
        tick();

        // CS hold: result waits in WAIT_CS until chip select drops
        bus_a.spi_message = c_M2;
        bus_a.spi_ready = 1;
        tick(3);
        bus_a.spi_cs = 1;
        tick(2);
        bus_a.core_done = 1; bus_a.core_result = c_C2;
        tick();
        bus_a.core_done = 0; bus_a.core_result = '0;
        tick(19);
        check("cs_proc_hold", 256'(bus_a.spi_processed), 256'(c_C1));
        check("cs_busy_hold", 256'(bus_a.busy), 256'(1));
        check("cs_rv_hold",   256'(bus_a.result_valid), 256'(0));
        bus_a.spi_cs = 0;
        tick();
        check("cs_proc_c1",   256'(bus_a.spi_processed), 256'(c_C1));
        tick();
        check("cs_proc_c2",   256'(bus_a.spi_processed), 256'(c_C2));
        check("cs_rv",        256'(bus_a.result_valid), 256'(1));
        bus_a.spi_ready = 0;
        tick();

        // Overrun: second frame during BUSY is flagged and discarded
        bus_a.spi_message = c_M3;
        bus_a.spi_ready = 1;
        tick();
        bus_a.spi_ready = 0;
        tick(2);
        bus_a.spi_message = c_M4;
        bus_a.spi_ready = 1;
        tick();
        check("ovr_flag",     256'(bus_a.overrun), 256'(1));
        check("ovr_data",     256'(bus_a.core_data), 256'(c_M3));
        bus_a.core_done = 1; bus_a.core_result = c_C3;
        tick();
        bus_a.core_done = 0; bus_a.core_result = '0;
        tick();
        check("ovr_proc",     256'(bus_a.spi_processed), 256'(c_C3));
        check("ovr_rv",       256'(bus_a.result_valid), 256'(1));
        check("ovr_sticky",   256'(bus_a.overrun), 256'(1));
        bus_a.spi_ready = 0;
        tick();
        bus_a.spi_ready = 1;
        tick();
        check("ovr_clear",    256'(bus_a.overrun), 256'(0));
        check("ovr_newdata",  256'(bus_a.core_data), 256'(c_M4));
        bus_a.spi_ready = 0;
        tick(2);

        // Reset in BUSY, late core_done must be ignored
        check("rst_mid_busy", 256'(bus_a.busy), 256'(1));
        rst = 1;
        tick();
        rst = 0;
        check("rst_mid_idle", 256'(bus_a.busy), 256'(0));
        bus_a.core_done = 1; bus_a.core_result = c_C1;
        tick();
        bus_a.core_done = 0; bus_a.core_result = '0;
        tick(3);
        check("rst_mid_proc", 256'(bus_a.spi_processed), 256'(0));
        check("rst_mid_rv",   256'(bus_a.result_valid), 256'(0));
        check("rst_mid_data", 256'(bus_a.core_data), 256'(0));
        check("rst_mid_key",  256'(bus_a.core_key), 256'(0));
        check("rst_mid_busy2",256'(bus_a.busy), 256'(0));

        // Timeout on TIMEOUT=8 instance: visible 9 cycles after core_start
        bus_b.spi_message = c_M1; bus_b.spi_key = c_K2;
        bus_b.spi_ready = 1;
        tick(2);
        check("to_start",     256'(bus_b.core_start), 256'(1));
        tick(8);
        check("to_early",     256'(bus_b.timeout_err), 256'(0));
        check("to_early_busy",256'(bus_b.busy), 256'(1));
        tick();
        check("to_flag",      256'(bus_b.timeout_err), 256'(1));
        check("to_idle",      256'(bus_b.busy), 256'(0));
        check("to_proc",      256'(bus_b.spi_processed), 256'(0));
        bus_b.spi_ready = 0;
        tick();

        // Nk=8 key, core_done on the last watchdog cycle wins over timeout
        bus_b.spi_message = c_M2;
        bus_b.spi_ready = 1;
        tick();
        check("nk8_key",      256'(bus_b.core_key), c_K2);
        check("nk8_to_clear", 256'(bus_b.timeout_err), 256'(0));
        tick(9);
        bus_b.core_done = 1; bus_b.core_result = c_C1;
        tick();
        bus_b.core_done = 0; bus_b.core_result = '0;
        tick();
        check("nk8_proc",     256'(bus_b.spi_processed), 256'(c_C1));
        check("nk8_rv",       256'(bus_b.result_valid), 256'(1));
        check("nk8_no_to",    256'(bus_b.timeout_err), 256'(0));
        bus_b.spi_ready = 0;
        tick(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
